// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit sampling, level-style byte-ready flag.
// data_o only updates on a correctly framed byte, so it is stable whenever byteReady_o is high.
module uart_byte_rx #(
   parameter int unsigned DELAY_FRAMES = 234
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       uart_rx_i,
   output logic [7:0] data_o,
   output logic       byteReady_o,
   output logic       frameError_o
);

   localparam int unsigned HALF_DELAY = DELAY_FRAMES / 2;
   localparam int unsigned CntW       = $clog2(DELAY_FRAMES) + 1;
   localparam logic [CntW-1:0] HalfLast = CntW'(HALF_DELAY - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(DELAY_FRAMES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStartCheck,
      StReadBits,
      StStopBit,
      StWaitIdle
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            rx_meta_q;
   logic            rxs;

   // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rx_meta_q <= 1'b1;
         rxs       <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx_i;
         rxs       <= rx_meta_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         data_o       <= '0;
         byteReady_o  <= 1'b0;
         frameError_o <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (!rxs) state_q <= StStartCheck;
            end
            StStartCheck: begin
               if (cnt_q == HalfLast) begin
                  cnt_q <= '0;
                  if (!rxs) begin
                     byteReady_o <= 1'b0;
                     bit_q       <= '0;
                     state_q     <= StReadBits;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StReadBits: begin
               if (cnt_q == BitLast) begin
                  cnt_q   <= '0;
                  shift_q <= {rxs, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= StStopBit;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStopBit: begin
               if (cnt_q == BitLast) begin
                  cnt_q <= '0;
                  if (rxs) begin
                     data_o       <= shift_q;
                     byteReady_o  <= 1'b1;
                     frameError_o <= 1'b0;
                     state_q      <= StIdle;
                  end else begin
                     frameError_o <= 1'b1;
                     state_q      <= StWaitIdle;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWaitIdle: begin
               cnt_q <= '0;
               if (rxs) state_q <= StIdle;
            end
            default: begin
               cnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 8 clocks per bit: reset, framing, glitch and abort scenarios.
module tb_uart_byte_rx;

   localparam int unsigned DF = 8;

   logic       clk_i;
   logic       reset_i;
   logic       uart_rx_i;
   logic [7:0] data_o;
   logic       byteReady_o;
   logic       frameError_o;

   int n_checks;
   int n_fail;

   uart_byte_rx #(.DELAY_FRAMES(DF)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .uart_rx_i   (uart_rx_i),
      .data_o      (data_o),
      .byteReady_o (byteReady_o),
      .frameError_o(frameError_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Drives one 8N1 frame; starts and ends 1 time unit after a rising edge.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx_i = bits[i];
         repeat (DF) @(posedge clk_i);
         #1;
      end
   endtask

   // Cycle counts from the start edge to byteReady_o falling / rising (-1 if never seen),
   // and whether data_o held still while byteReady_o was high.
   task automatic mon(input bit want_fall, output int t_fall, output int t_rise,
                      output bit stable);
      logic [7:0] held;
      int n;
      held   = data_o;
      n      = 0;
      t_fall = -1;
      t_rise = -1;
      stable = 1'b1;
      if (want_fall) begin
         while (n < 200) begin
            @(posedge clk_i); #1; n++;
            if (byteReady_o && data_o !== held) stable = 1'b0;
            if (!byteReady_o) begin t_fall = n; break; end
         end
      end
      while (n < 200) begin
         @(posedge clk_i); #1; n++;
         if (byteReady_o) begin t_rise = n; break; end
      end
   endtask

   task automatic test_reset();
      uart_rx_i = 1'b1;
      reset_i   = 1'b0;
      repeat (5) @(posedge clk_i);
      #1 reset_i = 1'b1;
      @(posedge clk_i); #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_o); end
         n_checks++;
         if (byteReady_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", byteReady_o); end
         n_checks++;
         if (frameError_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frameError_o); end
         repeat (20) @(posedge clk_i);
         #1;
      end
   endtask

   task automatic test_single_byte();
      int tf, tr;
      bit st;
      fork
         send_frame(8'h41, 1'b1);
         mon(1'b0, tf, tr, st);
      join
      n_checks++;
      if (tr < 76 || tr > 82) begin n_fail++; $display("FAIL single_rise_latency: got %0d want 76..82", tr); end
      n_checks++;
      if (data_o !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", data_o); end
      n_checks++;
      if (frameError_o !== 1'b0) begin n_fail++; $display("FAIL single_ferr: got %b want 0", frameError_o); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [2];
      int tf, tr;
      bit st;
      pat[0] = 8'h55;
      pat[1] = 8'hAA;
      for (int k = 0; k < 2; k++) begin
         fork
            send_frame(pat[k], 1'b1);
            mon(1'b1, tf, tr, st);
         join
         n_checks++;
         if (tf < 5 || tf > 9) begin n_fail++; $display("FAIL b2b_fall_%0d: got %0d want 5..9", k, tf); end
         n_checks++;
         if (tr < 76 || tr > 82) begin n_fail++; $display("FAIL b2b_rise_%0d: got %0d want 76..82", k, tr); end
         n_checks++;
         if (data_o !== pat[k]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", k, data_o, pat[k]); end
         n_checks++;
         if (st !== 1'b1) begin n_fail++; $display("FAIL b2b_stable_%0d: got %b want 1", k, st); end
      end
   endtask

   task automatic test_glitch();
      uart_rx_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 uart_rx_i = 1'b1;
      repeat (20) @(posedge clk_i);
      #1;
      n_checks++;
      if (byteReady_o !== 1'b1) begin n_fail++; $display("FAIL glitch_ready: got %b want 1", byteReady_o); end
      n_checks++;
      if (data_o !== 8'hAA) begin n_fail++; $display("FAIL glitch_data: got %h want aa", data_o); end
      n_checks++;
      if (frameError_o !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b want 0", frameError_o); end
   endtask

   task automatic test_frame_error();
      int tf, tr;
      bit st;
      send_frame(8'h33, 1'b0);
      uart_rx_i = 1'b0;
      repeat (20) @(posedge clk_i);
      #1 uart_rx_i = 1'b1;
      repeat (DF) @(posedge clk_i);
      #1;
      n_checks++;
      if (frameError_o !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", frameError_o); end
      n_checks++;
      if (byteReady_o !== 1'b0) begin n_fail++; $display("FAIL ferr_ready: got %b want 0", byteReady_o); end
      n_checks++;
      if (data_o !== 8'hAA) begin n_fail++; $display("FAIL ferr_data: got %h want aa", data_o); end
      fork
         send_frame(8'h08, 1'b1);
         mon(1'b0, tf, tr, st);
      join
      n_checks++;
      if (data_o !== 8'h08) begin n_fail++; $display("FAIL recover_data: got %h want 08", data_o); end
      n_checks++;
      if (byteReady_o !== 1'b1) begin n_fail++; $display("FAIL recover_ready: got %b want 1", byteReady_o); end
      n_checks++;
      if (frameError_o !== 1'b0) begin n_fail++; $display("FAIL recover_ferr: got %b want 0", frameError_o); end
   endtask

   task automatic test_reset_mid_frame();
      int tf, tr;
      bit st;
      // Start bit plus bits 0..3 of 0xFF, then abort.
      uart_rx_i = 1'b0;
      repeat (DF) @(posedge clk_i);
      #1 uart_rx_i = 1'b1;
      repeat (4 * DF) @(posedge clk_i);
      #1 reset_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b1;
      repeat (2 * DF) @(posedge clk_i);
      #1;
      n_checks++;
      if (data_o !== 8'h00) begin n_fail++; $display("FAIL abort_data: got %h want 00", data_o); end
      n_checks++;
      if (byteReady_o !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", byteReady_o); end
      n_checks++;
      if (frameError_o !== 1'b0) begin n_fail++; $display("FAIL abort_ferr: got %b want 0", frameError_o); end
      fork
         send_frame(8'h12, 1'b1);
         mon(1'b0, tf, tr, st);
      join
      n_checks++;
      if (tr < 76 || tr > 82) begin n_fail++; $display("FAIL post_abort_rise: got %0d want 76..82", tr); end
      n_checks++;
      if (data_o !== 8'h12) begin n_fail++; $display("FAIL post_abort_data: got %h want 12", data_o); end
      n_checks++;
      if (byteReady_o !== 1'b1) begin n_fail++; $display("FAIL post_abort_ready: got %b want 1", byteReady_o); end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset_i   = 1'b0;
      uart_rx_i = 1'b1;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
